mxint_accum_arbiter: RTL

MXINT_ACCUM_ARBITER -- requirements
Module: mxint_accum_arbiter

---
 rtl/mxint_arb_pkg.sv | 16 +
 rtl/mxint_accum_arbiter_rr_pick.sv | 30 +++
 rtl/mxint_accum_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mxint_arb_pkg.sv
// Shared constants for the MXINT accumulator-input arbiter: FSM state encoding and index-width helper.
package mxint_arb_pkg;

    typedef logic [0:0] arb_state_t;

    localparam arb_state_t IDLE   = 1'b0;
    localparam arb_state_t LOCKED = 1'b1;

    localparam int unsigned STAT_W = 32;

    // Width of a requester index for round-robin selection (at least one bit).
    function automatic int unsigned rr_sel_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mxint_accum_arbiter_rr_pick.sv
// Combinational round-robin finder: first set request at or after ptr, wrapping modulo N.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found_c,
    output logic [IW-1:0] idx_c
);

    // Scan from the farthest offset down so the nearest hit is written last and wins.
    always_comb begin : pick_search
        int j;
        found_c = 1'b0;
        idx_c   = '0;
        j       = 0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= int'(N)) begin
                j = j - int'(N);
            end
            if (req[IW'(j)]) begin
                found_c = 1'b1;
                idx_c   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/mxint_accum_arbiter.sv
// Round-robin arbiter that locks one requester for a full IN_DEPTH-beat MXINT accumulation group.
// Optional statistics counters are built when MXINT_ACCUM_ARB_STATS_EN is defined.
module mxint_accum_arbiter
    import mxint_arb_pkg::*;
#(
    parameter int unsigned DATA_IN_0_PRECISION_0 = 8,
    parameter int unsigned DATA_IN_0_PRECISION_1 = 4,
    parameter int unsigned BLOCK_SIZE            = 4,
    parameter int unsigned IN_DEPTH              = 2,
    parameter int unsigned N_REQ                 = 4,
    localparam int unsigned MW     = DATA_IN_0_PRECISION_0,
    localparam int unsigned EW     = DATA_IN_0_PRECISION_1,
    localparam int unsigned LANE_W = BLOCK_SIZE * MW,
    localparam int unsigned IW     = rr_sel_w(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ*LANE_W-1:0]   mreq_in,
    input  logic [N_REQ*EW-1:0]       ereq_in,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    output logic [LANE_W-1:0]         mdata_out_0,
    output logic [EW-1:0]             edata_out_0,
    output logic                      data_out_0_valid,
    input  logic                      data_out_0_ready,
    output logic [IW-1:0]             out_id,
    output logic                      out_last,
`ifdef MXINT_ACCUM_ARB_STATS_EN
    output logic [STAT_W-1:0]         stall_cycles,
    output logic [STAT_W-1:0]         groups_done,
`endif
    output logic                      busy
);

    localparam int unsigned CW = (IN_DEPTH <= 1) ? 1 : $clog2(IN_DEPTH);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] beat_q, beat_d;

    logic          pick_found_c;
    logic [IW-1:0] pick_idx_c;
    logic          accept_c;
    logic          last_c;

    logic [LANE_W-1:0] req_m [N_REQ];
    logic [EW-1:0]     req_e [N_REQ];

    for (genvar r = 0; r < int'(N_REQ); r++) begin : g_unpack
        assign req_m[r] = mreq_in[r*LANE_W +: LANE_W];
        assign req_e[r] = ereq_in[r*EW +: EW];
    end

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr_pick (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .found_c (pick_found_c),
        .idx_c   (pick_idx_c)
    );

    // Next state and zero-latency pass-through of the granted requester.
    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        rr_ptr_d         = rr_ptr_q;
        beat_d           = beat_q;
        req_ready        = '0;
        mdata_out_0      = '0;
        edata_out_0      = '0;
        data_out_0_valid = 1'b0;
        out_id           = '0;
        out_last         = 1'b0;
        busy             = 1'b0;
        accept_c         = 1'b0;
        last_c           = (beat_q == CW'(IN_DEPTH - 1));

        case (state_q)
            IDLE: begin
                if (pick_found_c) begin
                    grant_d = pick_idx_c;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                busy               = 1'b1;
                out_id             = grant_q;
                out_last           = last_c;
                mdata_out_0        = req_m[grant_q];
                edata_out_0        = req_e[grant_q];
                data_out_0_valid   = req_valid[grant_q];
                req_ready[grant_q] = data_out_0_ready;
                accept_c           = req_valid[grant_q] && data_out_0_ready;
                if (accept_c) begin
                    if (last_c) begin
                        beat_d   = '0;
                        rr_ptr_d = (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + IW'(1);
                        state_d  = IDLE;
                    end else begin
                        beat_d = beat_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            beat_q   <= beat_d;
        end
    end

`ifdef MXINT_ACCUM_ARB_STATS_EN
    logic [STAT_W-1:0] stall_q, stall_d;
    logic [STAT_W-1:0] groups_q, groups_d;

    // Saturating stall and completed-group counters.
    always_comb begin
        stall_d  = stall_q;
        groups_d = groups_q;
        if (data_out_0_valid && !data_out_0_ready && (stall_q != '1)) begin
            stall_d = stall_q + STAT_W'(1);
        end
        if (accept_c && last_c && (groups_q != '1)) begin
            groups_d = groups_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q  <= '0;
            groups_q <= '0;
        end else begin
            stall_q  <= stall_d;
            groups_q <= groups_d;
        end
    end

    assign stall_cycles = stall_q;
    assign groups_done  = groups_q;
`endif

endmodule
